ring_stop_router: RTL and testbench
===================================

Name: ring_stop_router

Overview:
- One stop on the unidirectional 16-bit flit ring that carries GPU-to-GPU network traffic.
- Sits directly downstream of each GPU's network interface:
  - accepts flits the GPU injects;
  - forwards through-traffic around the ring;
  - ejects flits addressed to this node back into the GPU's receive port.
- Flit format: [15:10] destination node ID, [9:0] payload.

Parameters:
- NODE_ID, 2, this stop's 6-bit node identifier; must match the attached GPU's ID.
- FIFO_DEPTH, 4, depth of the inject and eject FIFOs; power of two, minimum 2.
- STARVE_LIM, 8, consecutive lost arbitration cycles after which injection is forced to win.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- loc_in_data  in  16  flit from GPU (connects to GPU net_data_out)
- loc_in_valid  in  1  flit valid from GPU
- loc_in_ready  out  1  inject FIFO can accept (to GPU net_ready_in)
- loc_out_data  out  16  ejected flit to GPU (net_data_in)
- loc_out_valid  out  1  ejected flit valid (net_valid_in)
- loc_out_ready  in  1  GPU can accept (net_ready_out)
- ring_in_data  in  16  flit from upstream stop
- ring_in_valid  in  1  upstream flit valid
- ring_in_ready  out  1  this stop accepts the upstream flit
- ring_out_data  out  16  flit to downstream stop
- ring_out_valid  out  1  downstream flit valid
- ring_out_ready  in  1  downstream stop accepts
- inj_count  out  clog2(FIFO_DEPTH)+1  inject FIFO occupancy
- ej_count  out  clog2(FIFO_DEPTH)+1  eject FIFO occupancy

Behaviour:
- Handshake and reset:
  - A transfer occurs on any channel when valid && ready at a rising ACLK edge.
  - Data and valid are held stable until the transfer completes.
  - Reset (async assert, sync release): both FIFOs empty; ring_out_valid=0, ring_out_data=0; loc_out_valid=0; starve counter=0; inj_count=ej_count=0.
  - All ready outputs are forced to 0 while ARESETn is low.
  - Reset mid-operation discards every buffered flit.
- Inject FIFO:
  - loc_in_ready = !inj_full.
  - No push when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count stays exact through wrap.
- Output slot R (ring_out register):
  - R is free when !ring_out_valid || ring_out_ready.
  - At most one flit loads into R per cycle.
- Routing of ring_in:
  - dest == NODE_ID: eject. ring_in_ready = !ej_full.
  - Otherwise: through. ring_in_ready = R free && through is granted.
- Routing of the inject FIFO head:
  - dest == NODE_ID: loopback to the eject FIFO. Allowed only when no ring eject occurs that cycle and !ej_full.
  - Otherwise: competes for R.
- Arbitration for R:
  - Through traffic has priority.
  - Starve counter increments each cycle the inject head is non-self, non-empty, R is free, and through traffic wins.
  - When the counter reaches STARVE_LIM, injection wins that cycle and ring_in_ready is 0 for a through flit.
  - The counter clears whenever injection wins, or when the inject FIFO is empty.
- Latency:
  - ring_in to ring_out_valid: 1 cycle.
  - loc_in accepted to ring_out_valid: 2 cycles when uncontended.
  - ring_in (eject) to loc_out_valid: 1 cycle.
  - loopback: 2 cycles.
- Eject FIFO:
  - loc_out_data = head; loc_out_valid = !ej_empty.
  - Pop on loc_out_valid && loc_out_ready.
  - Same full and wrap rules as the inject FIFO.
- Back-pressure: a full eject FIFO stalls only eject-destined ring flits. Through traffic still flows.
- Flits are never dropped, duplicated or modified. Order is preserved per source path.

Test Plan:
- Reset release, inject 16'h0C55 (dest 3) on loc_in → ring_out_valid=1, data 16'h0C55 exactly 2 cycles after accept; inj_count returns to 0.
- ring_in 16'h0923 (dest 2, NODE_ID=2) → loc_out_data=16'h0923, loc_out_valid next cycle. With loc_out_ready=0, fill eject FIFO with 4 flits → ring_in_ready=0 for the 5th eject flit, while a through flit 16'h1001 still passes.
- Continuous through traffic on ring_in (dest 5) plus one inject flit (dest 7), STARVE_LIM=8 → inject flit appears on ring_out after exactly 8 lost cycles; ring_in_ready=0 that cycle; no through flit is lost.
- Hold ring_out_ready=0 → ring_out_data stable, ring_in_ready=0 for through flits; inject FIFO fills to 4 and loc_in_ready=0; push 8 flits with wrap after release → output order intact.
- Inject self-addressed 16'h0BEE (dest 2) → appears on loc_out 2 cycles later. The same cycle a ring eject flit arrives, the ring flit is ejected first.
- Assert ARESETn low with both FIFOs non-empty and ring_out_valid=1 → all valids and counts 0 immediately, all readies 0 during reset.

Source files
------------

// File: rtl/ring_stop_router.sv
// One stop on the unidirectional 16-bit GPU flit ring: injects local flits,
// forwards through-traffic and ejects flits addressed to this node.

module ring_stop_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage is not reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

module ring_stop_router #(
  parameter logic [5:0] NODE_ID    = 6'd2,
  parameter int         FIFO_DEPTH = 4,
  parameter int         STARVE_LIM = 8,
  localparam int        CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic [15:0]   loc_in_data,
  input  logic          loc_in_valid,
  output logic          loc_in_ready,
  output logic [15:0]   loc_out_data,
  output logic          loc_out_valid,
  input  logic          loc_out_ready,
  input  logic [15:0]   ring_in_data,
  input  logic          ring_in_valid,
  output logic          ring_in_ready,
  output logic [15:0]   ring_out_data,
  output logic          ring_out_valid,
  input  logic          ring_out_ready,
  output logic [CW-1:0] inj_count,
  output logic [CW-1:0] ej_count
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [15:0]   inj_head;
  logic          inj_full;
  logic          inj_empty;
  logic          inj_push;
  logic          inj_pop;
  logic          ej_full;
  logic          ej_empty;
  logic          ej_push;
  logic [15:0]   ej_data;
  logic [SW-1:0] starve_cnt;

  logic ring_self;
  logic inj_self;
  logic r_free;
  logic through_req;
  logic inj_req;
  logic starved;
  logic thr_ready;
  logic load_thr;
  logic inj_win;
  logic ring_eject;
  logic loopback;

  assign ring_self   = (ring_in_data[15:10] == NODE_ID);
  assign inj_self    = (inj_head[15:10] == NODE_ID);
  assign r_free      = !ring_out_valid || ring_out_ready;
  assign through_req = ring_in_valid && !ring_self;
  assign inj_req     = !inj_empty && !inj_self;
  assign starved     = (starve_cnt >= SW'(STARVE_LIM));

  // Through readiness does not depend on ring_in_valid; only a starved injector blocks it.
  assign thr_ready  = r_free && !(inj_req && starved);
  assign load_thr   = through_req && thr_ready;
  assign inj_win    = r_free && inj_req && (!through_req || starved);
  assign ring_eject = ring_in_valid && ring_self && !ej_full;
  assign loopback   = !inj_empty && inj_self && !ring_eject && !ej_full;

  assign inj_push = loc_in_valid && loc_in_ready;
  assign inj_pop  = inj_win || loopback;
  assign ej_push  = ring_eject || loopback;
  assign ej_data  = ring_eject ? ring_in_data : inj_head;

  assign loc_in_ready  = ARESETn && !inj_full;
  assign ring_in_ready = ARESETn && (ring_self ? !ej_full : thr_ready);
  assign loc_out_valid = !ej_empty;

  ring_stop_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_inj_fifo (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .push      (inj_push),
    .push_data (loc_in_data),
    .pop       (inj_pop),
    .head      (inj_head),
    .full      (inj_full),
    .empty     (inj_empty),
    .count     (inj_count)
  );

  ring_stop_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_ej_fifo (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .push      (ej_push),
    .push_data (ej_data),
    .pop       (loc_out_ready),
    .head      (loc_out_data),
    .full      (ej_full),
    .empty     (ej_empty),
    .count     (ej_count)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ring_out_valid <= 1'b0;
      ring_out_data  <= '0;
    end else if (r_free) begin
      ring_out_valid <= load_thr || inj_win;
      if (load_thr)     ring_out_data <= ring_in_data;
      else if (inj_win) ring_out_data <= inj_head;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      starve_cnt <= '0;
    end else if (inj_empty || inj_win) begin
      starve_cnt <= '0;
    end else if (inj_req && load_thr) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_ring_stop_router.sv
// Self-checking bench for ring_stop_router: scenario tasks with inline checks
// plus a per-source scoreboard that verifies every flit leaving either output.

module tb_ring_stop_router;

  localparam logic [5:0] NODE = 6'd2;
  localparam int         LIM  = 8;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [15:0] loc_in_data = '0;
  logic        loc_in_valid = 1'b0;
  logic        loc_in_ready;
  logic [15:0] loc_out_data;
  logic        loc_out_valid;
  logic        loc_out_ready = 1'b1;
  logic [15:0] ring_in_data = '0;
  logic        ring_in_valid = 1'b0;
  logic        ring_in_ready;
  logic [15:0] ring_out_data;
  logic        ring_out_valid;
  logic        ring_out_ready = 1'b1;
  logic [2:0]  inj_count;
  logic [2:0]  ej_count;

  int vectors = 0;
  int miscompares = 0;

  // Expected flits, one queue per source path so only per-path order is enforced.
  logic [15:0] ring_thr_q[$];
  logic [15:0] ring_inj_q[$];
  logic [15:0] loc_ej_q[$];
  logic [15:0] loc_lb_q[$];

  always #5 ACLK = ~ACLK;

  ring_stop_router #(.NODE_ID(NODE), .FIFO_DEPTH(4), .STARVE_LIM(LIM)) dut (
    .ACLK           (ACLK),
    .ARESETn        (ARESETn),
    .loc_in_data    (loc_in_data),
    .loc_in_valid   (loc_in_valid),
    .loc_in_ready   (loc_in_ready),
    .loc_out_data   (loc_out_data),
    .loc_out_valid  (loc_out_valid),
    .loc_out_ready  (loc_out_ready),
    .ring_in_data   (ring_in_data),
    .ring_in_valid  (ring_in_valid),
    .ring_in_ready  (ring_in_ready),
    .ring_out_data  (ring_out_data),
    .ring_out_valid (ring_out_valid),
    .ring_out_ready (ring_out_ready),
    .inj_count      (inj_count),
    .ej_count       (ej_count)
  );

  always @(negedge ACLK) begin
    if (ARESETn && ring_out_valid && ring_out_ready) begin
      vectors++;
      if (ring_thr_q.size() > 0 && ring_thr_q[0] === ring_out_data) void'(ring_thr_q.pop_front());
      else if (ring_inj_q.size() > 0 && ring_inj_q[0] === ring_out_data) void'(ring_inj_q.pop_front());
      else begin
        miscompares++;
        $display("FAIL ring_out_sb: got %h, expected through %h or inject %h", ring_out_data,
                 (ring_thr_q.size() > 0) ? ring_thr_q[0] : 16'hxxxx,
                 (ring_inj_q.size() > 0) ? ring_inj_q[0] : 16'hxxxx);
      end
    end
    if (ARESETn && loc_out_valid && loc_out_ready) begin
      vectors++;
      if (loc_ej_q.size() > 0 && loc_ej_q[0] === loc_out_data) void'(loc_ej_q.pop_front());
      else if (loc_lb_q.size() > 0 && loc_lb_q[0] === loc_out_data) void'(loc_lb_q.pop_front());
      else begin
        miscompares++;
        $display("FAIL loc_out_sb: got %h, expected eject %h or loopback %h", loc_out_data,
                 (loc_ej_q.size() > 0) ? loc_ej_q[0] : 16'hxxxx,
                 (loc_lb_q.size() > 0) ? loc_lb_q[0] : 16'hxxxx);
      end
    end
  end

  // Sample mid-cycle; any input handshake seen here completes on the next edge.
  task automatic sample();
    @(negedge ACLK);
    if (ring_in_valid && ring_in_ready) begin
      if (ring_in_data[15:10] == NODE) loc_ej_q.push_back(ring_in_data);
      else ring_thr_q.push_back(ring_in_data);
    end
    if (loc_in_valid && loc_in_ready) begin
      if (loc_in_data[15:10] == NODE) loc_lb_q.push_back(loc_in_data);
      else ring_inj_q.push_back(loc_in_data);
    end
  endtask

  task automatic adv();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    int left;
    left = ring_thr_q.size() + ring_inj_q.size() + loc_ej_q.size() + loc_lb_q.size();
    while (left != 0 && n < 200) begin
      sample();
      adv();
      n++;
      left = ring_thr_q.size() + ring_inj_q.size() + loc_ej_q.size() + loc_lb_q.size();
    end
    vectors++;
    if (left != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d flits outstanding after 200 cycles, expected 0", name, left);
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    @(negedge ACLK);
    vectors++; if (ring_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_ring_out_valid: got %b expected 0", ring_out_valid); end
    vectors++; if (ring_out_data !== 16'h0) begin miscompares++; $display("FAIL rst_ring_out_data: got %h expected 0000", ring_out_data); end
    vectors++; if (loc_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_loc_out_valid: got %b expected 0", loc_out_valid); end
    vectors++; if (inj_count !== 3'd0 || ej_count !== 3'd0) begin miscompares++; $display("FAIL rst_counts: got inj %0d ej %0d expected 0 0", inj_count, ej_count); end
    vectors++; if (loc_in_ready !== 1'b0 || ring_in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_readies: got loc %b ring %b expected 0 0", loc_in_ready, ring_in_ready); end
    adv();
    ARESETn = 1'b1;
    sample();
    vectors++; if (loc_in_ready !== 1'b1 || ring_in_ready !== 1'b1) begin miscompares++; $display("FAIL rel_readies: got loc %b ring %b expected 1 1", loc_in_ready, ring_in_ready); end
    adv();
  endtask

  task automatic test_inject();
    loc_in_data = 16'h0C55; loc_in_valid = 1'b1;
    sample();
    vectors++; if (loc_in_ready !== 1'b1) begin miscompares++; $display("FAIL inj_accept: got %b expected 1", loc_in_ready); end
    adv();
    loc_in_valid = 1'b0;
    sample();
    vectors++; if (ring_out_valid !== 1'b0 || inj_count !== 3'd1) begin miscompares++; $display("FAIL inj_cycle1: got valid %b count %0d expected 0 1", ring_out_valid, inj_count); end
    adv();
    sample();
    vectors++; if (ring_out_valid !== 1'b1 || ring_out_data !== 16'h0C55) begin miscompares++; $display("FAIL inj_cycle2: got valid %b data %h expected 1 0c55", ring_out_valid, ring_out_data); end
    vectors++; if (inj_count !== 3'd0) begin miscompares++; $display("FAIL inj_count_empty: got %0d expected 0", inj_count); end
    adv();
    wait_drain("inject");
  endtask

  task automatic test_eject();
    bit acc = 1'b0;
    int n = 0;
    ring_in_data = 16'h0923; ring_in_valid = 1'b1;
    sample();
    vectors++; if (ring_in_ready !== 1'b1) begin miscompares++; $display("FAIL ej_accept: got %b expected 1", ring_in_ready); end
    adv();
    ring_in_valid = 1'b0;
    sample();
    vectors++; if (loc_out_valid !== 1'b1 || loc_out_data !== 16'h0923) begin miscompares++; $display("FAIL ej_latency: got valid %b data %h expected 1 0923", loc_out_valid, loc_out_data); end
    adv();
    loc_out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ring_in_data = 16'h0900 + 16'(i); ring_in_valid = 1'b1;
      sample();
      vectors++; if (ring_in_ready !== 1'b1) begin miscompares++; $display("FAIL ej_fill_%0d: got ready %b expected 1", i, ring_in_ready); end
      adv();
    end
    ring_in_data = 16'h0905;
    sample();
    vectors++; if (ring_in_ready !== 1'b0 || ej_count !== 3'd4) begin miscompares++; $display("FAIL ej_full_stall: got ready %b count %0d expected 0 4", ring_in_ready, ej_count); end
    adv();
    // The stalled eject flit is withdrawn so the same channel can carry a through flit.
    ring_in_data = 16'h1001;
    sample();
    vectors++; if (ring_in_ready !== 1'b1) begin miscompares++; $display("FAIL ej_full_through_ready: got %b expected 1", ring_in_ready); end
    adv();
    ring_in_valid = 1'b0;
    sample();
    vectors++; if (ring_out_valid !== 1'b1 || ring_out_data !== 16'h1001) begin miscompares++; $display("FAIL ej_full_through_out: got valid %b data %h expected 1 1001", ring_out_valid, ring_out_data); end
    adv();
    ring_in_data = 16'h0905; ring_in_valid = 1'b1; loc_out_ready = 1'b1;
    do begin
      sample();
      acc = ring_in_ready;
      adv();
      n++;
    end while (!acc && n < 10);
    ring_in_valid = 1'b0;
    vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL ej_resume: got accepted %b expected 1", acc); end
    wait_drain("eject");
  endtask

  task automatic test_starve();
    logic [15:0] thr = 16'h1400;
    int lost = 0;
    bit stalled = 1'b0;
    ring_in_data = thr; ring_in_valid = 1'b1;
    loc_in_data = 16'h1CAA; loc_in_valid = 1'b1;
    sample();
    vectors++; if (loc_in_ready !== 1'b1 || ring_in_ready !== 1'b1) begin miscompares++; $display("FAIL stv_start: got loc %b ring %b expected 1 1", loc_in_ready, ring_in_ready); end
    adv();
    loc_in_valid = 1'b0; thr++; ring_in_data = thr;
    for (int k = 1; k <= 20 && !stalled; k++) begin
      sample();
      if (ring_in_ready) begin
        lost++;
        adv();
        thr++; ring_in_data = thr;
      end else begin
        stalled = 1'b1;
        adv();
      end
    end
    vectors++; if (stalled !== 1'b1 || lost != LIM) begin miscompares++; $display("FAIL stv_lost_cycles: got stalled %b lost %0d expected 1 %0d", stalled, lost, LIM); end
    sample();
    vectors++; if (ring_out_valid !== 1'b1 || ring_out_data !== 16'h1CAA) begin miscompares++; $display("FAIL stv_inject_out: got valid %b data %h expected 1 1caa", ring_out_valid, ring_out_data); end
    for (int k = 0; k < 3; k++) begin
      if (ring_in_ready) begin adv(); thr++; ring_in_data = thr; end
      else adv();
      sample();
    end
    if (ring_in_ready) begin adv(); ring_in_valid = 1'b0; end
    else begin adv(); ring_in_valid = 1'b0; ring_thr_q.push_back(16'h0); end
    wait_drain("starve");
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    bit full_seen = 1'b0;
    bit ring_done = 1'b0;
    ring_out_ready = 1'b0;
    ring_in_data = 16'h1401; ring_in_valid = 1'b1;
    sample();
    vectors++; if (ring_in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_first_accept: got %b expected 1", ring_in_ready); end
    adv();
    ring_in_data = 16'h1402;
    sample();
    vectors++; if (ring_out_valid !== 1'b1 || ring_out_data !== 16'h1401) begin miscompares++; $display("FAIL bp_hold_out: got valid %b data %h expected 1 1401", ring_out_valid, ring_out_data); end
    vectors++; if (ring_in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_through_blocked: got %b expected 0", ring_in_ready); end
    adv();
    for (int i = 0; i < 8 && !full_seen; i++) begin
      loc_in_data = 16'h1C01 + 16'(n_acc); loc_in_valid = 1'b1;
      sample();
      if (loc_in_ready) begin n_acc++; adv(); end
      else full_seen = 1'b1;
    end
    vectors++; if (n_acc != 4 || inj_count !== 3'd4 || loc_in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_inj_full: got accepted %0d count %0d ready %b expected 4 4 0", n_acc, inj_count, loc_in_ready); end
    vectors++; if (ring_out_data !== 16'h1401 || ring_in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stable: got data %h ring ready %b expected 1401 0", ring_out_data, ring_in_ready); end
    adv();
    ring_out_ready = 1'b1;
    for (int i = 0; i < 60 && n_acc < 12; i++) begin
      loc_in_data = 16'h1C01 + 16'(n_acc); loc_in_valid = 1'b1;
      sample();
      ring_done = ring_in_valid && ring_in_ready;
      if (loc_in_ready) n_acc++;
      adv();
      if (ring_done) ring_in_valid = 1'b0;
    end
    loc_in_valid = 1'b0;
    vectors++; if (n_acc != 12 || ring_in_valid !== 1'b0) begin miscompares++; $display("FAIL bp_wrap_push: got accepted %0d through pending %b expected 12 0", n_acc, ring_in_valid); end
    wait_drain("backpressure");
  endtask

  task automatic test_loopback();
    loc_in_data = 16'h0BEE; loc_in_valid = 1'b1;
    sample();
    vectors++; if (loc_in_ready !== 1'b1) begin miscompares++; $display("FAIL lb_accept: got %b expected 1", loc_in_ready); end
    adv();
    loc_in_valid = 1'b0;
    sample();
    vectors++; if (loc_out_valid !== 1'b0) begin miscompares++; $display("FAIL lb_cycle1: got valid %b expected 0", loc_out_valid); end
    adv();
    sample();
    vectors++; if (loc_out_valid !== 1'b1 || loc_out_data !== 16'h0BEE) begin miscompares++; $display("FAIL lb_cycle2: got valid %b data %h expected 1 0bee", loc_out_valid, loc_out_data); end
    adv();
    loc_in_data = 16'h0BAD; loc_in_valid = 1'b1;
    sample();
    adv();
    loc_in_valid = 1'b0;
    ring_in_data = 16'h0911; ring_in_valid = 1'b1;
    sample();
    vectors++; if (ring_in_ready !== 1'b1) begin miscompares++; $display("FAIL lb_ring_eject_ready: got %b expected 1", ring_in_ready); end
    adv();
    ring_in_valid = 1'b0;
    sample();
    vectors++; if (loc_out_valid !== 1'b1 || loc_out_data !== 16'h0911) begin miscompares++; $display("FAIL lb_ring_first: got valid %b data %h expected 1 0911", loc_out_valid, loc_out_data); end
    adv();
    sample();
    vectors++; if (loc_out_valid !== 1'b1 || loc_out_data !== 16'h0BAD) begin miscompares++; $display("FAIL lb_after_ring: got valid %b data %h expected 1 0bad", loc_out_valid, loc_out_data); end
    adv();
    wait_drain("loopback");
  endtask

  task automatic test_reset_mid();
    ring_out_ready = 1'b0; loc_out_ready = 1'b0;
    ring_in_data = 16'h1403; ring_in_valid = 1'b1;
    sample(); adv();
    ring_in_data = 16'h0930;
    sample(); adv();
    ring_in_valid = 1'b0;
    loc_in_data = 16'h1C20; loc_in_valid = 1'b1;
    sample(); adv();
    loc_in_data = 16'h1C21;
    sample(); adv();
    loc_in_valid = 1'b0;
    sample();
    vectors++; if (ring_out_valid !== 1'b1 || inj_count !== 3'd2 || ej_count !== 3'd1) begin miscompares++; $display("FAIL mid_setup: got valid %b inj %0d ej %0d expected 1 2 1", ring_out_valid, inj_count, ej_count); end
    #2 ARESETn = 1'b0;
    #1;
    ring_thr_q.delete(); ring_inj_q.delete(); loc_ej_q.delete(); loc_lb_q.delete();
    vectors++; if (ring_out_valid !== 1'b0 || loc_out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valids: got ring %b loc %b expected 0 0", ring_out_valid, loc_out_valid); end
    vectors++; if (inj_count !== 3'd0 || ej_count !== 3'd0) begin miscompares++; $display("FAIL mid_counts: got inj %0d ej %0d expected 0 0", inj_count, ej_count); end
    vectors++; if (loc_in_ready !== 1'b0 || ring_in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_readies: got loc %b ring %b expected 0 0", loc_in_ready, ring_in_ready); end
    adv();
    ARESETn = 1'b1; ring_out_ready = 1'b1; loc_out_ready = 1'b1;
    sample();
    vectors++; if (ring_out_valid !== 1'b0 || loc_out_valid !== 1'b0 || inj_count !== 3'd0) begin miscompares++; $display("FAIL mid_release: got ring %b loc %b inj %0d expected 0 0 0", ring_out_valid, loc_out_valid, inj_count); end
    adv();
  endtask

  initial begin
    test_reset();
    test_inject();
    test_eject();
    test_starve();
    test_backpressure();
    test_loopback();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
